// File: rtl/i2c_qtr_tick.sv
// Quarter-SCL-period timebase: counts system clocks while running and
// emits a one-cycle tick at the end of each quarter, plus the quarter index.
module i2c_qtr_tick #(
  parameter int QTR_CYC = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = (QTR_CYC > 1) ? $clog2(QTR_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(QTR_CYC - 1);

  logic [CW-1:0] cnt_reg;
  logic [1:0]    phase_reg;

  assign tick  = run && (cnt_reg == LAST);
  assign phase = phase_reg;

  // Held at zero while idle so every transaction starts on a clean Q0.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_reg   <= '0;
      phase_reg <= 2'd0;
    end else if (tick) begin
      cnt_reg   <= '0;
      phase_reg <= phase_reg + 2'd1;
    end else begin
      cnt_reg   <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Pads are open-drain (drive 0 or release); SCL is never read back.
module i2c_master_ctrl #(
  parameter int QTR_CYC = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  input  logic       enable,
  input  logic       rw,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       done,
  output logic       ack_err,
  inout  wire        i2c_sda,
  inout  wire        i2c_scl
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WDATA, S_WACK, S_RDATA, S_MACK, S_STOP
  } state_t;

  state_t      state_reg, state_next;
  logic        tick;
  logic [1:0]  phase;
  logic        sample, slot_end, last_bit;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  tx_shift_reg, rx_shift_reg, data_reg;
  logic        rw_reg, nack_reg;
  logic [1:0]  sda_sync_reg;
  logic        sda_low_reg, scl_low_reg, sda_low_next, scl_low_next;
  logic        done_reg, ready_reg, ack_err_reg;
  logic [7:0]  data_out_reg;

  i2c_qtr_tick #(.QTR_CYC(QTR_CYC)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (state_reg != S_IDLE),
    .tick  (tick),
    .phase (phase)
  );

  assign sample   = tick && (phase == 2'd2);
  assign slot_end = tick && (phase == 2'd3);
  assign last_bit = (bit_cnt_reg == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (enable) state_next = S_START;
      S_START:    if (slot_end) state_next = S_ADDR;
      S_ADDR:     if (slot_end && last_bit) state_next = S_ADDR_ACK;
      S_ADDR_ACK: if (slot_end) state_next = nack_reg ? S_STOP : (rw_reg ? S_RDATA : S_WDATA);
      S_WDATA:    if (slot_end && last_bit) state_next = S_WACK;
      S_WACK:     if (slot_end) state_next = S_STOP;
      S_RDATA:    if (slot_end && last_bit) state_next = S_MACK;
      S_MACK:     if (slot_end) state_next = S_STOP;
      S_STOP:     if (slot_end) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Pad drive per state and quarter; 1 means pull the line low.
  always_comb begin
    sda_low_next = 1'b0;
    scl_low_next = 1'b0;
    case (state_reg)
      S_START: begin
        sda_low_next = phase[1];
        scl_low_next = (phase == 2'd3);
      end
      S_ADDR, S_WDATA: begin
        sda_low_next = !tx_shift_reg[7];
        scl_low_next = !phase[1];
      end
      S_ADDR_ACK, S_WACK, S_RDATA, S_MACK: scl_low_next = !phase[1];
      S_STOP: begin
        sda_low_next = (phase != 2'd3);
        scl_low_next = !phase[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sda_low_reg  <= 1'b0;
      scl_low_reg  <= 1'b0;
      sda_sync_reg <= 2'b11;
    end else begin
      sda_low_reg  <= sda_low_next;
      scl_low_reg  <= scl_low_next;
      sda_sync_reg <= {sda_sync_reg[0], i2c_sda};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg  <= 3'd0;
      tx_shift_reg <= 8'h00;
      rx_shift_reg <= 8'h00;
      data_reg     <= 8'h00;
      rw_reg       <= 1'b0;
      nack_reg     <= 1'b0;
      ack_err_reg  <= 1'b0;
      data_out_reg <= 8'h00;
      done_reg     <= 1'b0;
      ready_reg    <= 1'b1;
    end else begin
      if (state_reg == S_IDLE && enable) begin
        tx_shift_reg <= {addr, rw};
        data_reg     <= data_in;
        rw_reg       <= rw;
        ack_err_reg  <= 1'b0;
        bit_cnt_reg  <= 3'd0;
      end
      if (sample) begin
        case (state_reg)
          S_ADDR_ACK, S_WACK: nack_reg <= sda_sync_reg[1];
          S_RDATA:            rx_shift_reg <= {rx_shift_reg[6:0], sda_sync_reg[1]};
          default: ;
        endcase
      end
      // Bit counter wraps 7->0 on its own, ready for the next byte.
      if (slot_end) begin
        case (state_reg)
          S_ADDR, S_WDATA: begin
            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
            tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
          end
          S_RDATA: begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (last_bit) data_out_reg <= rx_shift_reg;
          end
          S_ADDR_ACK: begin
            if (nack_reg) ack_err_reg  <= 1'b1;
            else          tx_shift_reg <= data_reg;
          end
          S_WACK: if (nack_reg) ack_err_reg <= 1'b1;
          default: ;
        endcase
      end
      done_reg  <= (state_reg == S_STOP) && slot_end;
      ready_reg <= (state_next == S_IDLE);
    end
  end

  assign i2c_sda  = sda_low_reg ? 1'b0 : 1'bz;
  assign i2c_scl  = scl_low_reg ? 1'b0 : 1'bz;
  assign data_out = data_out_reg;
  assign ready    = ready_reg;
  assign done     = done_reg;
  assign ack_err  = ack_err_reg;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: pull-ups plus a behavioural slave at address 0x07,
// a table of single-byte transactions and a few hand-written corner sequences.
module tb_i2c_master_ctrl;

  localparam int QTR = 4;
  localparam int FULL_CYC = 80 * QTR;
  localparam int NACK_CYC = 44 * QTR;
  localparam logic [6:0] SLV_ADDR = 7'h07;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] addr = 7'h00;
  logic [7:0] data_in = 8'h00;
  logic       enable = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] data_out;
  logic       ready, done, ack_err;
  wire        i2c_sda, i2c_scl;

  pullup (i2c_sda);
  pullup (i2c_scl);

  always #5 clk = ~clk;

  i2c_master_ctrl #(.QTR_CYC(QTR)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .enable   (enable),
    .rw       (rw),
    .data_out (data_out),
    .ready    (ready),
    .done     (done),
    .ack_err  (ack_err),
    .i2c_sda  (i2c_sda),
    .i2c_scl  (i2c_scl)
  );

  // Behavioural slave, sampled on the falling system clock edge.
  localparam logic [1:0] M_IDLE = 2'd0, M_ADDR = 2'd1, M_WDATA = 2'd2, M_RDATA = 2'd3;
  logic [1:0] s_mode = M_IDLE;
  logic [3:0] s_bit = 4'd0;
  logic [7:0] s_shift = 8'h00;
  logic [7:0] s_addr_byte = 8'h00;
  logic [7:0] s_data_byte = 8'h00;
  logic       s_drive = 1'b0;
  logic       s_mack = 1'b0;
  logic       scl_prev = 1'b1, sda_prev = 1'b1;
  int         start_cnt = 0, stop_cnt = 0;
  logic [7:0] slave_tx = 8'h00;
  wire        scl_now = (i2c_scl === 1'b1);
  wire        sda_now = (i2c_sda === 1'b1);

  assign i2c_sda = s_drive ? 1'b0 : 1'bz;

  always @(negedge clk) begin
    if (scl_prev && scl_now && sda_prev && !sda_now) begin
      start_cnt <= start_cnt + 1;
      s_mode <= M_ADDR; s_bit <= 4'd0; s_shift <= 8'h00; s_drive <= 1'b0; s_mack <= 1'b0;
    end else if (scl_prev && scl_now && !sda_prev && sda_now) begin
      stop_cnt <= stop_cnt + 1;
      s_mode <= M_IDLE; s_drive <= 1'b0;
    end else if (!scl_prev && scl_now) begin
      if (s_mode != M_IDLE) begin
        if (s_bit < 4'd8 && (s_mode == M_ADDR || s_mode == M_WDATA))
          s_shift <= {s_shift[6:0], sda_now};
        if (s_bit == 4'd8 && s_mode == M_RDATA) s_mack <= sda_now;
        s_bit <= s_bit + 4'd1;
      end
    end else if (scl_prev && !scl_now) begin
      case (s_mode)
        M_ADDR:
          if (s_bit == 4'd8) begin
            s_addr_byte <= s_shift;
            if (s_shift[7:1] == SLV_ADDR) s_drive <= 1'b1;
            else s_mode <= M_IDLE;
          end else if (s_bit == 4'd9) begin
            s_bit <= 4'd0; s_shift <= 8'h00;
            if (s_addr_byte[0]) begin s_mode <= M_RDATA; s_drive <= !slave_tx[7]; end
            else begin s_mode <= M_WDATA; s_drive <= 1'b0; end
          end
        M_WDATA:
          if (s_bit == 4'd8) begin s_data_byte <= s_shift; s_drive <= 1'b1; end
          else if (s_bit == 4'd9) begin s_drive <= 1'b0; s_mode <= M_IDLE; end
        M_RDATA:
          if (s_bit >= 4'd1 && s_bit <= 4'd7) s_drive <= !slave_tx[4'd7 - s_bit];
          else if (s_bit == 4'd8) s_drive <= 1'b0;
          else if (s_bit == 4'd9) s_mode <= M_IDLE;
        default: ;
      endcase
    end
    scl_prev <= scl_now;
    sda_prev <= sda_now;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Presents one request for a single clock edge; returns on the negedge after accept.
  task automatic start_txn(input logic [6:0] a, input logic r, input logic [7:0] d);
    @(negedge clk);
    addr = a; rw = r; data_in = d; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic wait_done(input int base, output int cyc);
    cyc = base;
    while (cyc < base + 2000) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) break;
    end
  endtask

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] din;
    logic [7:0] stx;
    int         exp_cyc;
    logic       exp_err;
    logic [7:0] exp_dout;
    logic [7:0] exp_saddr;
    logic [7:0] exp_sdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc, st0, sp0, done_seen;

    vecs[0] = '{7'h07, 1'b0, 8'hA5, 8'h00, FULL_CYC, 1'b0, 8'h00, 8'h0E, 8'hA5};
    vecs[1] = '{7'h07, 1'b1, 8'h00, 8'h3C, FULL_CYC, 1'b0, 8'h3C, 8'h0F, 8'h00};
    vecs[2] = '{7'h12, 1'b0, 8'h55, 8'h00, NACK_CYC, 1'b1, 8'h3C, 8'h24, 8'h00};
    vecs[3] = '{7'h07, 1'b0, 8'h5A, 8'h00, FULL_CYC, 1'b0, 8'h3C, 8'h0E, 8'h5A};
    vecs[4] = '{7'h12, 1'b1, 8'h00, 8'h00, NACK_CYC, 1'b1, 8'h3C, 8'h25, 8'h00};
    vecs[5] = '{7'h07, 1'b1, 8'h00, 8'h81, FULL_CYC, 1'b0, 8'h81, 8'h0F, 8'h00};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_ack_err", ack_err, 0);
    check("rst_sda", i2c_sda, 1);
    check("rst_scl", i2c_scl, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      slave_tx = vecs[i].stx;
      st0 = start_cnt; sp0 = stop_cnt;
      start_txn(vecs[i].addr, vecs[i].rw, vecs[i].din);
      check("accept_ready_low", ready, 0);
      wait_done(0, cyc);
      $display("txn %0d addr=0x%02h rw=%0d din=0x%02h cyc=%0d ack_err=%0d data_out=0x%02h slave_addr=0x%02h",
               i, vecs[i].addr, vecs[i].rw, vecs[i].din, cyc, ack_err, data_out, s_addr_byte);
      check("done_latency", cyc, vecs[i].exp_cyc);
      check("done_ready", ready, 1);
      check("ack_err", ack_err, vecs[i].exp_err);
      check("data_out", data_out, vecs[i].exp_dout);
      check("slave_addr_byte", s_addr_byte, vecs[i].exp_saddr);
      check("start_seen", start_cnt - st0, 1);
      check("stop_seen", stop_cnt - sp0, 1);
      if (!vecs[i].rw && !vecs[i].exp_err) check("slave_data_byte", s_data_byte, vecs[i].exp_sdata);
      if (vecs[i].rw && !vecs[i].exp_err) check("master_nack_bit", s_mack, 1);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      repeat (3) @(negedge clk);
    end

    // enable pulsed mid-transaction with different data must be ignored
    st0 = start_cnt;
    start_txn(7'h07, 1'b0, 8'hA5);
    repeat (49) @(negedge clk);
    data_in = 8'hFF; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_done(50, cyc);
    $display("txn busy-enable cyc=%0d slave_data=0x%02h", cyc, s_data_byte);
    check("busy_latency", cyc, FULL_CYC);
    check("busy_slave_data", s_data_byte, 8'hA5);
    repeat (6) @(negedge clk);
    check("busy_no_retrigger", ready, 1);
    check("busy_start_count", start_cnt - st0, 1);

    // enable held across done: back-to-back transactions
    st0 = start_cnt;
    @(negedge clk);
    addr = 7'h07; rw = 1'b0; data_in = 8'h3C; enable = 1'b1;
    @(negedge clk);
    wait_done(0, cyc);
    $display("txn held-enable #1 cyc=%0d slave_data=0x%02h", cyc, s_data_byte);
    check("held_latency1", cyc, FULL_CYC);
    check("held_ready_gap", ready, 1);
    check("held_slave_data1", s_data_byte, 8'h3C);
    @(negedge clk);
    check("held_reaccept", ready, 0);
    data_in = 8'hC3;
    enable = 1'b0;
    wait_done(0, cyc);
    $display("txn held-enable #2 cyc=%0d slave_data=0x%02h", cyc, s_data_byte);
    check("held_latency2", cyc, FULL_CYC);
    check("held_slave_data2", s_data_byte, 8'h3C);
    check("held_start_count", start_cnt - st0, 2);
    repeat (3) @(negedge clk);

    // reset in the middle of a write: lines released, no STOP, no done
    sp0 = stop_cnt;
    start_txn(7'h07, 1'b0, 8'h99);
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("txn mid-reset sda=%0d scl=%0d ready=%0d", i2c_sda, i2c_scl, ready);
    check("midrst_sda", i2c_sda, 1);
    check("midrst_scl", i2c_scl, 1);
    check("midrst_ready", ready, 1);
    check("midrst_data_out", data_out, 8'h00);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    check("midrst_no_stop", stop_cnt - sp0, 0);
    check("midrst_idle", ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-master, single-byte I2C transaction engine. One transaction is START, 7-bit address + R/W, slave ACK, one data byte, ACK/NACK, STOP.
- Sits under the byte-sequencing wrapper. The wrapper presents a byte and pulses `enable`, then waits for `done` and `ready` before presenting the next byte.
- Drives the open-drain `i2c_sda` and `i2c_scl` pads directly; the board supplies the pull-ups.

Parameters:
- QTR_CYC, 250: system clocks per quarter SCL period. At 100 MHz this gives 100 kHz SCL. Legal range is 2 or more.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  7  slave address.
- data_in  in  8  byte to write.
- enable  in  1  start request; level-sampled.
- rw  in  1  0 = write, 1 = read.
- data_out  out  8  byte read from the slave.
- ready  out  1  engine idle and able to accept `enable`.
- done  out  1  one-cycle pulse at the end of a transaction.
- ack_err  out  1  slave NACKed the last transaction; sticky until the next accept.
- i2c_sda  inout  1  open-drain data line.
- i2c_scl  inout  1  open-drain clock line.

Behaviour:
- Open-drain drive:
  - Each line is either driven 0 or left high-Z; a line is never driven 1.
  - SDA is read from the pad.
  - SCL is never read back; clock stretching is not supported.
- Reset values: `ready`=1, `done`=0, `data_out`=0, `ack_err`=0, both lines released, state IDLE, quarter counter 0.
- Accept:
  - In IDLE with `ready`=1 and `enable`=1 on a clock edge, latch `addr`, `rw` and `data_in`, clear `ack_err`, and enter START.
  - `ready` drops on that same edge.
  - `enable` is ignored while not IDLE.
  - If `enable` is still high when the engine returns to IDLE, a new transaction starts.
- Timing:
  - A quarter counter runs 0..QTR_CYC-1 and advances the phase.
  - Each bit slot is 4 quarters (Q0..Q3).
  - In a data bit, SCL is low in Q0-Q1 and released in Q2-Q3.
  - SDA changes only at the start of Q0.
  - SDA is sampled at the end of Q2.
- States: IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, MACK, STOP.
  - START (1 slot): Q0-Q1 both lines released; Q2 SDA low; Q3 SDA low and SCL low.
  - ADDR (8 slots): sends {addr, rw} MSB first.
  - ADDR_ACK (1 slot): SDA released and sampled. Sampled 0 goes to WDATA when rw=0, or RDATA when rw=1. Sampled 1 sets `ack_err` and goes to STOP.
  - WDATA (8 slots): sends the latched data MSB first, then goes to WACK.
  - WACK (1 slot): SDA sampled. Sampled 1 sets `ack_err`. Always goes to STOP.
  - RDATA (8 slots): SDA released; bits are shifted in MSB first.
  - MACK (1 slot): master drives NACK (SDA released). `data_out` is updated with the shifted byte at the start of this slot. Goes to STOP.
  - STOP (1 slot): Q0-Q1 SDA low and SCL low; Q2 SCL released; Q3 SDA released.
  - At the end of STOP: `done`=1 for exactly one cycle, `ready`=1 on the same edge, return to IDLE.
- Latency from the accept edge to the `done` pulse:
  - Normal write or read: 20 slots, i.e. 80*QTR_CYC cycles.
  - Address NACK: 11 slots, i.e. 44*QTR_CYC cycles.
- A NACKed transaction leaves `data_out` unchanged.
- Reset asserted mid-transaction: next edge returns to reset values and releases both lines. No STOP is generated.
- `done` and `ready` are registered outputs.

Decomposition:
- No shared package. The state encoding is a localparam enum internal to the module.
- One natural sub-module: `i2c_qtr_tick`, a quarter-period tick generator taking QTR_CYC and producing a one-cycle tick plus a 2-bit phase.
- All else stays flat: FSM, bit counter, shift registers, pad drivers.

Test Plan (QTR_CYC=4, bench has pull-ups and a slave model at address 0x07):
- Reset: hold `rst` 3 cycles -> `ready`=1, `done`=0, `data_out`=0x00, both lines read 1.
- Write: addr=0x07, rw=0, data_in=0xA5, 1-cycle `enable` pulse, slave ACKs both bytes.
  - Slave captures address byte 0x0E and data byte 0xA5.
  - START shows SDA falling while SCL is high; STOP shows SDA rising while SCL is high.
  - `done` pulses exactly 320 cycles after accept; `ack_err`=0; `ready`=1.
- Read: addr=0x07, rw=1, slave returns 0x3C.
  - Slave sees address byte 0x0F.
  - `data_out`=0x3C; master leaves SDA high in the 9th data slot.
  - `done` pulses after 320 cycles.
- Address NACK: addr=0x12 (no slave at that address) -> `ack_err`=1, `done` after 176 cycles, `data_out` unchanged.
- `enable` while busy: pulse `enable` at cycle 50 with data_in=0xFF -> ignored; the transaction still transfers 0xA5.
- `enable` held high across `done`: two back-to-back transactions; `ready` is high for exactly one cycle between them.
- Mid-transaction reset: assert `rst` at cycle 100 -> next edge has both lines released and `ready`=1; no `done` pulse.
